// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and operand-signedness helpers for the RV32M unit
package muldiv_pkg;
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;
    typedef enum logic [1:0] {IDLE, CALC, DONE} muldiv_state_e;
    function automatic logic is_signed_a(muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction
    function automatic logic is_signed_b(muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the datapath and the multiply/divide unit
interface muldiv_if #(parameter int WIDTH = 32);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] result;
    modport master(output start, op, a, b, flush, input busy, valid, result);
    modport slave(input start, op, a, b, flush, output busy, valid, result);
endinterface

// File: rtl/muldiv_core.sv
// muldiv_core: unsigned iterative shift-add multiplier / restoring divider
// After the last step {hi,lo} is the product, or hi=remainder and lo=quotient.
module muldiv_core #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi_nx,
    output logic [WIDTH-1:0] lo_nx
);
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, md_q, md_d;
    logic [WIDTH:0]   t;
    always_comb begin
        hi_nx = hi_q;
        lo_nx = lo_q;
        t = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (is_div) begin
                // t[WIDTH] set means the trial subtraction went negative: restore
                t = {hi_nx, lo_nx[WIDTH-1]} - {1'b0, md_q};
                hi_nx = t[WIDTH] ? {hi_nx[WIDTH-2:0], lo_nx[WIDTH-1]} : t[WIDTH-1:0];
                lo_nx = {lo_nx[WIDTH-2:0], ~t[WIDTH]};
            end else begin
                t = {1'b0, hi_nx} + (lo_nx[0] ? {1'b0, md_q} : '0);
                hi_nx = t[WIDTH:1];
                lo_nx = {t[0], lo_nx[WIDTH-1:1]};
            end
        end
    end
    assign hi_d = load ? '0 : step ? hi_nx : hi_q;
    assign lo_d = load ? a_in : step ? lo_nx : lo_q;
    assign md_d = load ? b_in : md_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
            md_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            md_q <= md_d;
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M multiply/divide with FSM, sign handling and single-cycle special cases
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);
    localparam int ITER = WIDTH / BITS_PER_CYCLE;
    localparam int CW   = $clog2(ITER + 1);
    muldiv_state_e      state_q, state_d;
    muldiv_op_e         op_q, op_d, op_in;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               sa, sb, div0, ovf, load, step;
    logic [WIDTH-1:0]   a_mag, b_mag, hi_nx, lo_nx, spec, quo, rem, fin;
    logic [2*WIDTH-1:0] prod;
    assign op_in = muldiv_op_e'(bus.op);
    assign sa    = is_signed_a(op_in) & bus.a[WIDTH-1];
    assign sb    = is_signed_b(op_in) & bus.b[WIDTH-1];
    assign a_mag = sa ? -bus.a : bus.a;
    assign b_mag = sb ? -bus.b : bus.b;
    assign div0  = bus.op[2] && bus.b == '0;
    assign ovf   = bus.op[2] && !bus.op[0] && bus.a == {1'b1, {(WIDTH-1){1'b0}}} && &bus.b;
    assign spec  = div0 ? (bus.op[1] ? bus.a : '1) : (bus.op[1] ? '0 : bus.a);
    // Magnitudes are computed first; the sign is re-applied on the final step
    assign prod  = neg_q ? -{hi_nx, lo_nx} : {hi_nx, lo_nx};
    assign quo   = neg_q ? -lo_nx : lo_nx;
    assign rem   = neg_q ? -hi_nx : hi_nx;
    assign fin   = op_q[2] ? (op_q[1] ? rem : quo) :
                   (op_q == OP_MUL ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH]);
    muldiv_core #(.WIDTH(WIDTH), .BITS_PER_CYCLE(BITS_PER_CYCLE)) u_core (
        .clk(clk), .rst(rst), .load(load), .step(step), .is_div(op_q[2]),
        .a_in(a_mag), .b_in(b_mag), .hi_nx(hi_nx), .lo_nx(lo_nx)
    );
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        result_d = result_q;
        load     = 1'b0;
        step     = 1'b0;
        case (state_q)
            IDLE: if (bus.start && !bus.flush) begin
                op_d     = op_in;
                neg_d    = (op_in[2] && op_in[1]) ? sa : sa ^ sb;
                load     = !(div0 || ovf);
                cnt_d    = CW'(ITER);
                state_d  = (div0 || ovf) ? DONE : CALC;
                result_d = (div0 || ovf) ? spec : result_q;
            end
            CALC: begin
                step     = 1'b1;
                cnt_d    = cnt_q - CW'(1);
                state_d  = cnt_q == CW'(1) ? DONE : CALC;
                result_d = cnt_q == CW'(1) ? fin : result_q;
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end
    assign bus.busy   = state_q != IDLE;
    assign bus.valid  = state_q == DONE;
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of latency, arithmetic, special cases, flush and reset
module tb_muldiv_unit;
    import muldiv_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0, errors = 0, cyc = 0, lat = 0, tv = 0, t0 = 0, seen = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    muldiv_if #(.WIDTH(32)) b1 ();
    muldiv_if #(.WIDTH(32)) b4 ();
    muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go1(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int exp_lat, input logic [31:0] exp_res, input string tag);
        b1.start = 1'b1; b1.op = op; b1.a = a; b1.b = b;
        tick();
        b1.start = 1'b0; b1.a = $urandom; b1.b = $urandom;
        lat = 1;
        while (!b1.valid && lat < 100) begin tick(); lat++; end
        tv = cyc;
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, b1.result, exp_res);
        tick();
        check({tag, " pulse"}, {31'b0, b1.valid}, 32'd0);
    endtask

    initial begin
        b1.start = 0; b1.op = 0; b1.a = 0; b1.b = 0; b1.flush = 0;
        b4.start = 0; b4.op = 0; b4.a = 0; b4.b = 0; b4.flush = 0;
        tick(); tick();
        check("reset busy", {31'b0, b1.busy}, 32'd0);
        check("reset valid", {31'b0, b1.valid}, 32'd0);
        check("reset result", b1.result, 32'd0);
        rst = 1'b1;
        tick();
        go1(OP_MUL, 32'd7, 32'hFFFFFFFD, 33, 32'hFFFFFFEB, "mul");
        go1(OP_MULH, 32'd7, 32'hFFFFFFFD, 33, 32'hFFFFFFFF, "mulh");
        go1(OP_MULHU, 32'd7, 32'hFFFFFFFD, 33, 32'h00000006, "mulhu");
        // async reset in the middle of a MUL
        b1.start = 1'b1; b1.op = OP_MUL; b1.a = 32'd7; b1.b = 32'd6;
        tick();
        b1.start = 1'b0;
        repeat (5) tick();
        check("mid busy", {31'b0, b1.busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rst busy", {31'b0, b1.busy}, 32'd0);
        check("rst result", b1.result, 32'd0);
        tick();
        rst = 1'b1;
        seen = 0;
        repeat (40) begin tick(); seen |= int'(b1.valid); end
        check("rst no valid", 32'(seen), 32'd0);
        go1(OP_DIV, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFD, "div");
        go1(OP_REM, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, "rem");
        go1(OP_DIVU, 32'd100, 32'd7, 33, 32'd14, "divu");
        go1(OP_REMU, 32'd100, 32'd7, 33, 32'd2, "remu");
        go1(OP_DIV, 32'd5, 32'd0, 1, 32'hFFFFFFFF, "div0");
        go1(OP_REM, 32'd5, 32'd0, 1, 32'd5, "rem0");
        go1(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, "div ovf");
        go1(OP_REM, 32'h80000000, 32'hFFFFFFFF, 1, 32'd0, "rem ovf");
        // a start while busy must be ignored
        b1.start = 1'b1; b1.op = OP_DIVU; b1.a = 32'd100; b1.b = 32'd7;
        tick();
        b1.start = 1'b0;
        lat = 1;
        repeat (9) begin tick(); lat++; end
        b1.start = 1'b1; b1.op = OP_DIV; b1.a = 32'd200; b1.b = 32'd3;
        tick(); lat++;
        b1.start = 1'b0;
        while (!b1.valid && lat < 100) begin tick(); lat++; end
        check("ignore latency", 32'(lat), 32'd33);
        check("ignore result", b1.result, 32'd14);
        tick();
        // flush during CALC
        b1.start = 1'b1; b1.op = OP_DIVU; b1.a = 32'd50; b1.b = 32'd5;
        tick();
        b1.start = 1'b0;
        repeat (19) tick();
        b1.flush = 1'b1;
        tick();
        b1.flush = 1'b0;
        check("flush busy", {31'b0, b1.busy}, 32'd0);
        seen = 0;
        repeat (40) begin tick(); seen |= int'(b1.valid); end
        check("flush no valid", 32'(seen), 32'd0);
        check("flush result", b1.result, 32'd14);
        // flush and start together in IDLE
        b1.start = 1'b1; b1.flush = 1'b1; b1.op = OP_DIVU; b1.a = 32'd9; b1.b = 32'd3;
        tick();
        b1.start = 1'b0; b1.flush = 1'b0;
        check("flush+start busy", {31'b0, b1.busy}, 32'd0);
        // flush in DONE still shows valid
        b1.start = 1'b1; b1.op = OP_DIV; b1.a = 32'd5; b1.b = 32'd0;
        tick();
        b1.start = 1'b0; b1.flush = 1'b1;
        #1;
        check("flush done valid", {31'b0, b1.valid}, 32'd1);
        check("flush done result", b1.result, 32'hFFFFFFFF);
        tick();
        b1.flush = 1'b0;
        check("flush done idle", {31'b0, b1.busy}, 32'd0);
        // back-to-back MULHSU
        go1(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFF, "mulhsu1");
        t0 = tv;
        go1(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFF, "mulhsu2");
        check("b2b spacing", 32'(tv - t0), 32'd34);
        // four bits per cycle
        b4.start = 1'b1; b4.op = OP_MULHSU; b4.a = 32'hFFFFFFFF; b4.b = 32'hFFFFFFFF;
        tick();
        b4.start = 1'b0;
        lat = 1;
        while (!b4.valid && lat < 100) begin tick(); lat++; end
        check("bpc4 latency", 32'(lat), 32'd9);
        check("bpc4 result", b4.result, 32'hFFFFFFFF);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
